// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame geometry, command bytes and parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_state_e;

   // start + 8 data + parity + stop
   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned BIT_IDX_W  = 4;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Resets to 1 (idle bus level) so a reset never produces a spurious edge.
module ps2_line_sync (
   input  logic clk,
   input  logic clrn,
   input  logic line,
   output logic level,
   output logic fall_c
);

   logic meta;
   logic prev;

   // synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (!clrn) begin
         meta  <= 1'b1;
         level <= 1'b1;
         prev  <= 1'b1;
      end else begin
         meta  <= line;
         level <= meta;
         prev  <= level;
      end
   end

   assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK).
// Optional frame timeout is compiled in with PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       sys_clk,
   input  logic       clrn,
   input  logic       wrn,
   input  logic [7:0] din,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       timeout
);

   import ps2_pkg::*;

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [BIT_IDX_W-1:0] IDX_PARITY = BIT_IDX_W'(DATA_BITS);
   localparam logic [BIT_IDX_W-1:0] IDX_LAST   = BIT_IDX_W'(FRAME_BITS - 2);

   ps2_state_e           state, state_nxt;
   logic [INH_W-1:0]     inh_cnt, inh_cnt_nxt;
   logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nxt;
   logic [7:0]           tx_byte, tx_byte_nxt;
   logic                 clk_oe_nxt, data_oe_nxt;
   logic                 busy_nxt, done_nxt, err_nxt;

   logic clk_level, clk_fall;
   logic data_level, data_fall_unused;

   ps2_line_sync u_clk_sync (
      .clk    (sys_clk),
      .clrn   (clrn),
      .line   (ps2_clk),
      .level  (clk_level),
      .fall_c (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk    (sys_clk),
      .clrn   (clrn),
      .line   (ps2_data),
      .level  (data_level),
      .fall_c (data_fall_unused)
   );

`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            timeout_nxt;
`else
   // timeout length only matters when the watchdog is compiled in
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   // state, datapath and output registers
   always_ff @(posedge sys_clk) begin
      if (!clrn) begin
         state       <= IDLE;
         inh_cnt     <= '0;
         bit_idx     <= '0;
         tx_byte     <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
         to_cnt      <= '0;
         timeout     <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         inh_cnt     <= inh_cnt_nxt;
         bit_idx     <= bit_idx_nxt;
         tx_byte     <= tx_byte_nxt;
         ps2_clk_oe  <= clk_oe_nxt;
         ps2_data_oe <= data_oe_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
`ifdef PS2_HOST_TX_TIMEOUT_EN
         to_cnt      <= to_cnt_nxt;
         timeout     <= timeout_nxt;
`endif
      end
   end

   // next-state and next-output logic; both lines released unless a state drives them
   always_comb begin
      state_nxt   = state;
      inh_cnt_nxt = inh_cnt;
      bit_idx_nxt = bit_idx;
      tx_byte_nxt = tx_byte;
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      err_nxt     = err;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt_nxt  = to_cnt;
      timeout_nxt = timeout;
`endif

      case (state)
         IDLE: begin
            if (!wrn) begin
               tx_byte_nxt = din;
               err_nxt     = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
               timeout_nxt = 1'b0;
`endif
               busy_nxt    = 1'b1;
               inh_cnt_nxt = '0;
               clk_oe_nxt  = 1'b1;
               state_nxt   = INHIBIT;
            end
         end

         INHIBIT: begin
            clk_oe_nxt = 1'b1;
            if (inh_cnt == INH_LAST) begin
               data_oe_nxt = 1'b1;
               state_nxt   = RTS;
            end else begin
               inh_cnt_nxt = inh_cnt + INH_W'(1);
            end
         end

         RTS: begin
            // clock released, start bit (data low) kept until the device clocks it
            data_oe_nxt = 1'b1;
            bit_idx_nxt = '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            to_cnt_nxt  = '0;
`endif
            state_nxt   = SHIFT;
         end

         SHIFT: begin
            data_oe_nxt = ps2_data_oe;
            if (clk_fall) begin
               bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
               if (bit_idx < IDX_PARITY) begin
                  data_oe_nxt = ~tx_byte[bit_idx[2:0]];
               end else if (bit_idx == IDX_PARITY) begin
                  data_oe_nxt = ~odd_parity(tx_byte);
               end else if (bit_idx == IDX_LAST) begin
                  data_oe_nxt = 1'b0;
                  state_nxt   = ACK;
               end
            end
         end

         ACK: begin
            if (clk_fall) begin
               err_nxt   = data_level;
               state_nxt = WAIT_IDLE;
            end
         end

         WAIT_IDLE: begin
            if (clk_level && data_level) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // watchdog from clock release until the ACK has been taken
      if (state == SHIFT || state == ACK) begin
         to_cnt_nxt = to_cnt + TO_W'(1);
         if (to_cnt == TO_LAST) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            err_nxt     = 1'b1;
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
         end
      end
`endif
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Timeout scenario is included when PS2_HOST_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;

   import ps2_pkg::*;

   localparam int unsigned INH = 20;
   localparam int unsigned TO  = 1000;

   logic       sys_clk = 1'b0;
   logic       clrn    = 1'b0;
   logic       wrn     = 1'b1;
   logic [7:0] din     = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_line, ps2_data_line;
   logic       ps2_clk_oe, ps2_data_oe, busy, done, err, timeout;

   // wired-AND bus: either side may pull a line low
   assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .sys_clk     (sys_clk),
      .clrn        (clrn),
      .wrn         (wrn),
      .din         (din),
      .ps2_clk     (ps2_clk_line),
      .ps2_data    (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .timeout     (timeout)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // free-running activity counters, sampled 1 ns after each rising edge
   int cyc = 0, inh_tot = 0, rts_tot = 0, done_tot = 0;
   always @(posedge sys_clk) begin
      #1;
      cyc++;
      if (ps2_clk_oe && !ps2_data_oe) inh_tot++;
      if (ps2_clk_oe && ps2_data_oe)  rts_tot++;
      if (done) done_tot++;
   end

   task automatic write_byte(input logic [7:0] b);
      @(negedge sys_clk);
      wrn = 1'b0;
      din = b;
      @(negedge sys_clk);
      wrn = 1'b1;
   endtask

   // device side: wait for clock release, then clock n_edges bits, sampling data before each rise
   task automatic dev_frame(input int n_edges, input bit ack_low, input bit inject,
                            output logic [10:0] cap, output bit ok, output int rel_cyc);
      ok      = 1'b0;
      cap     = '1;
      rel_cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (!ps2_clk_oe && ps2_data_oe) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      rel_cyc = cyc;
      cap[0]  = ps2_data_line;
      repeat (5) @(negedge sys_clk);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack_low) begin
            dev_data = 1'b0;
            @(negedge sys_clk);
         end
         dev_clk = 1'b0;
         repeat (10) @(negedge sys_clk);
         if (k <= 10) cap[k] = ps2_data_line;
         dev_clk  = 1'b1;
         dev_data = 1'b1;
         if (inject && k == 2) begin
            wrn = 1'b0;
            din = CMD_RESET;
            @(negedge sys_clk);
            wrn = 1'b1;
         end
         if (k < n_edges) repeat (10) @(negedge sys_clk);
      end
   endtask

   task automatic wait_not_busy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // one full frame with all frame-level checks
   task automatic send(input string tag, input logic [7:0] b, input logic [7:0] exp_byte,
                       input bit exp_par, input bit ack_low, input bit inject);
      logic [10:0] cap;
      bit          ok;
      int          rel, inh0, rts0, done0;
      inh0  = inh_tot;
      rts0  = rts_tot;
      done0 = done_tot;
      write_byte(b);
      chk({tag, "_busy_set"}, 32'(busy), 32'd1);
      dev_frame(11, ack_low, inject, cap, ok, rel);
      chk({tag, "_release_seen"}, 32'(ok), 32'd1);
      wait_not_busy(ok);
      chk({tag, "_busy_clear"}, 32'(ok), 32'd1);
      repeat (5) @(negedge sys_clk);
      chk({tag, "_start"},   32'(cap[0]),   32'd0);
      chk({tag, "_byte"},    32'(cap[8:1]), 32'(exp_byte));
      chk({tag, "_parity"},  32'(cap[9]),   32'(exp_par));
      chk({tag, "_stop"},    32'(cap[10]),  32'd1);
      chk({tag, "_inhibit"}, 32'(inh_tot - inh0),  32'(INH));
      chk({tag, "_rts"},     32'(rts_tot - rts0),  32'd1);
      chk({tag, "_done"},    32'(done_tot - done0), 32'd1);
      chk({tag, "_err"},     32'(err),     ack_low ? 32'd0 : 32'd1);
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
      chk({tag, "_oe_idle"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
   endtask

   initial begin
      logic [10:0] cap;
      bit          ok;
      int          rel;

      // reset state
      clrn = 1'b0;
      repeat (3) @(negedge sys_clk);
      clrn = 1'b1;
      chk("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
      chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      chk("rst_busy",    32'(busy),        32'd0);
      chk("rst_done",    32'(done),        32'd0);
      chk("rst_err",     32'(err),         32'd0);
      chk("rst_timeout", 32'(timeout),     32'd0);
      chk("rst_state",   32'(dut.state),   32'(ps2_pkg::IDLE));

      // 0xED: data bits 1,0,1,1,0,1,1,1 (six ones) -> parity 1
      send("led", CMD_SET_LED, 8'hED, 1'b1, 1'b1, 1'b0);
      // all zeros -> parity 1; single one -> parity 0
      send("zero", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      send("one",  8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
      // device does not pull data on the ACK edge
      send("nack", CMD_RESET, 8'hFF, 1'b1, 1'b0, 1'b0);
      // write of 0xFF during SHIFT must be ignored
      send("ignore", CMD_SET_LED, 8'hED, 1'b1, 1'b1, 1'b1);

      // reset in the middle of a frame, after the fifth clock edge
      write_byte(CMD_SET_LED);
      dev_frame(5, 1'b1, 1'b0, cap, ok, rel);
      chk("mid_release_seen", 32'(ok), 32'd1);
      chk("mid_data_driven", 32'(ps2_data_oe), 32'd1);
      clrn = 1'b0;
      @(negedge sys_clk);
      clrn = 1'b1;
      chk("mid_rst_oe",    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_state", 32'(dut.state), 32'(ps2_pkg::IDLE));
      repeat (5) @(negedge sys_clk);
      // 0xF4 = 1111_0100 has five ones -> parity 0
      send("recover", CMD_ENABLE, 8'hF4, 1'b0, 1'b1, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // device stops clocking after edge 3; watchdog fires TO cycles after release
      begin
         int done0;
         done0 = done_tot;
         write_byte(CMD_ENABLE);
         dev_frame(3, 1'b1, 1'b0, cap, ok, rel);
         chk("to_release_seen", 32'(ok), 32'd1);
         ok = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            @(negedge sys_clk);
            if (timeout) begin
               ok = 1'b1;
               break;
            end
         end
         chk("to_fired",   32'(ok), 32'd1);
         chk("to_delay",   32'(cyc - rel), 32'(TO));
         chk("to_done",    32'(done), 32'd1);
         chk("to_err",     32'(err),  32'd1);
         chk("to_busy",    32'(busy), 32'd0);
         chk("to_oe",      {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
         repeat (5) @(negedge sys_clk);
         chk("to_done_cnt", 32'(done_tot - done0), 32'd1);
         chk("to_sticky",  32'(timeout), 32'd1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
